// File: rtl/fir_decimator_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fir_pkg
// Description : Shared constants and sample type for the FIR decimator stage.
//               Default sample width, decimation factor and FIFO depth, plus
//               the sample typedef used by the filter chain.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int FIR_DATA_W             = 16;
  localparam int FIR_DECIM_DEFAULT      = 4;
  localparam int FIR_FIFO_DEPTH_DEFAULT = 8;

  typedef logic [FIR_DATA_W-1:0] fir_sample_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_decimator_if.sv
`default_nettype none
// ============================================================================
// Interface   : fir_decimator_if
// Description : Sample streams around the decimator.
//               in_data/in_valid  : FIR samples into the decimator (no ready,
//                                   every valid sample is consumed)
//               out_data/out_valid/out_ready : decimated results, valid/ready
//               Modports: master = surrounding environment (FIR + consumer),
//                         slave  = the decimator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_decimator_if #(
  parameter int DATA_W = fir_pkg::FIR_DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid
  );

endinterface : fir_decimator_if
`default_nettype wire

// File: rtl/fir_decimator_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock first-word-fall-through FIFO. o_dout always shows
//               the head entry (zero while empty). A push while full is only
//               performed when a pop happens in the same cycle.
// Ports       : clk, reset (async, active-low)
//               i_push / i_din       : write request and data
//               i_pop                : remove head entry
//               o_dout               : head entry
//               o_full / o_empty     : occupancy flags
//               o_count              : occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int            c_AW      = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH   = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0] c_CNT_ONE = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_en;
  logic w_rd_en;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  assign w_rd_en = i_pop && !w_empty;
  // When full, the slot being written is the head being popped this edge.
  assign w_wr_en = i_push && (!w_full || w_rd_en);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stale memory is masked so the output reads zero while empty.
  assign o_dout  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule : fir_sync_fifo
`default_nettype wire

// File: rtl/fir_decimator.sv
`default_nettype none
// ============================================================================
// Module      : fir_decimator
// Description : Decimates the FIR output stream by DECIM. Pick mode keeps the
//               first sample of each group of DECIM valid samples; average
//               mode (macro FIR_DECIM_AVG_EN defined) outputs the group sum
//               shifted right by log2(DECIM). Results go through a FWFT FIFO
//               to a valid/ready consumer. A sticky flag records results
//               dropped because the FIFO was full.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-low reset
//               bus       - fir_decimator_if.slave: in_data/in_valid,
//                           out_data/out_valid/out_ready
//               fill      - FIFO occupancy
//               overflow  - sticky drop flag
//               ovf_clear - synchronous clear of overflow (a drop wins)
// Config      : FIR_DECIM_AVG_EN - enables averaging (DECIM power of two)
// Revision    : 1.0 - initial release
// ============================================================================
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W     = FIR_DATA_W,
  parameter int DECIM      = FIR_DECIM_DEFAULT,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  fir_decimator_if.slave                bus,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  input  logic                          ovf_clear
);

  localparam int                c_PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(DECIM - 1);
  localparam logic [c_PH_W-1:0] c_PH_ONE  = c_PH_W'(1);

  logic [c_PH_W-1:0] r_phase;
  logic              r_overflow;

  logic              w_push_req;
  logic [DATA_W-1:0] w_push_data;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;

  // Phase counts valid samples, not cycles, so gaps keep group alignment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
    end else if (bus.in_valid) begin
      r_phase <= (r_phase == c_PH_LAST) ? '0 : r_phase + c_PH_ONE;
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int c_ACC_W = DATA_W + c_PH_W;

  logic [c_ACC_W-1:0] r_acc;
  logic [c_ACC_W-1:0] w_sum;

  // Wide enough for DECIM full-scale samples, so the sum never wraps.
  assign w_sum = r_acc + c_ACC_W'(bus.in_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (bus.in_valid) begin
      r_acc <= (r_phase == c_PH_LAST) ? '0 : w_sum;
    end
  end

  assign w_push_req  = bus.in_valid && (r_phase == c_PH_LAST);
  assign w_push_data = DATA_W'(w_sum >> c_PH_W);
`else
  assign w_push_req  = bus.in_valid && (r_phase == '0);
  assign w_push_data = bus.in_data;
`endif

  assign w_pop  = !w_empty && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_push_req && (!w_full || w_pop);
  assign w_drop = w_push_req && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

  fir_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_push_data),
    .o_dout  (bus.out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fill)
  );

  assign bus.out_valid = !w_empty;
  assign overflow      = r_overflow;

endmodule : fir_decimator
`default_nettype wire

// File: doc/fir_decimator.md
# fir_decimator

Downstream stage of the 19-tap low-pass FIR filter. Accepts the filter's 16-bit output stream and decimates it by a fixed integer factor, either by keeping one sample per group or by averaging each group. Results are buffered in a small FIFO and presented on a valid/ready interface to the next consumer, e.g. a sample sink or serializer. A sticky flag records any sample lost to back-pressure.

## Interface
- `DATA_W`, 16: sample width; matches the FIR output.
- `DECIM`, 4: decimation factor, ≥2. Must be a power of two when `FIR_DECIM_AVG_EN` is defined.
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_data` in `DATA_W`: unsigned sample from the FIR.
- `in_valid` in 1: `in_data` is valid this cycle. No back-pressure to the FIR; every valid sample is consumed.
- `out_data` out `DATA_W`: head of the FIFO.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_data` this cycle.
- `fill` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `overflow` out 1: sticky flag; a decimated sample was dropped.
- `ovf_clear` in 1: synchronous clear of `overflow`.

## Operation
- **Phase counter.** `phase` counts 0..`DECIM`-1. It advances by one on each `in_valid`, wraps to 0 after `DECIM`-1, and holds otherwise.
- **Pick mode (macro undefined).** When `in_valid` and `phase`==0, `in_data` is the decimated sample and a push is requested.
- **Pop.** A pop occurs when `out_valid && out_ready`. The FIFO is first-word-fall-through, so `out_data` always shows the head entry.
- **Full with pop.** A push and pop in the same cycle while full are both performed; `fill` is unchanged.
- **Full without pop.** A push while full and not popping is dropped. `overflow` is set, and `phase` and the accumulator still advance, so group alignment is kept.
- **Empty with push.** A push into an empty FIFO is visible on the next cycle; there is no bypass.
- **Overflow priority.** `ovf_clear` and a new drop in the same cycle leave `overflow`=1.
- **Reset.** Reset asserted mid-operation discards all FIFO contents and any partial group.
- **Reset values.** `out_valid`=0, `out_data`=0, `fill`=0, `overflow`=0, `phase`=0, accumulator=0, FIFO pointers=0.

## Timing
- **Pick mode latency.** A sample with `in_valid` at edge k appears on `out_valid`/`out_data` after edge k, i.e. in cycle k+1, if the FIFO was empty.
- **Average mode latency.** The result is pushed at the edge that accepts the `phase`==`DECIM`-1 sample and appears in the next cycle.
- **Pop timing.** A pop at edge k updates `out_data` to the next entry, or drops `out_valid` if the FIFO is now empty, in cycle k+1.
- **Sustained rate.** With `out_ready` held at 1, one result is produced per `DECIM` valid inputs, with no bubbles.
- `in_valid` may be gapped arbitrarily; decimation counts valid samples, not cycles.

## Configuration
- **`FIR_DECIM_AVG_EN` defined.** An accumulator of width `DATA_W+$clog2(DECIM)` sums each group of `DECIM` valid samples.
  - On `phase`==`DECIM`-1, the pushed value is (acc + `in_data`) >> `$clog2(DECIM)`, truncated toward zero.
  - In the same cycle the accumulator reloads to 0.
- **`FIR_DECIM_AVG_EN` undefined.** Pick mode only; no accumulator is instantiated.

## Structure
- **Package `fir_pkg`.** Holds `FIR_DATA_W`=16, `FIR_DECIM_DEFAULT`=4, `FIR_FIFO_DEPTH_DEFAULT`=8, and the sample typedef `fir_sample_t` (`logic [FIR_DATA_W-1:0]`).
- **Sub-module `fir_sync_fifo`.** Parameterised on width and depth; ports push/pop/din/dout/full/empty/count; first-word-fall-through.
- **Top level.** Holds the phase counter, the optional accumulator and the overflow logic.

## Test plan
- **Pick mode ramp.** Reset, then `in_data`=0,1,2,…,15 with `in_valid`=1 and `out_ready`=1. Outputs must be 0,4,8,12, each one cycle after the accepting edge.
- **Gapped input.** Same ramp with `in_valid` toggling 1,0,1,0. Outputs must still be 0,4,8,12, with no extra samples.
- **Back-pressure and overflow.** Hold `out_ready`=0 and feed 40 samples (10 pushes). `fill` must saturate at 8 and `overflow` must go to 1. Draining must return the first 8 picks, 0,4,…,28. Then pulse `ovf_clear` and `overflow` must go to 0.
- **Full with simultaneous pop.** Fill the FIFO, then push and pop in the same cycle. `fill` must stay 8 and `overflow` must stay 0.
- **Average mode.** Define `FIR_DECIM_AVG_EN` and feed inputs 10,11,12,13, then 65535 ×4. Outputs must be 11 (46>>2), then 65535, with no wrap.
- **Reset mid-group.** Feed 2 samples, assert `reset` asynchronously mid-cycle, then release. `out_valid`, `fill` and `overflow` must go to 0 immediately. The next sample must be treated as `phase` 0.
